if_else_branch_sequencer: RTL and testbench
===========================================

# if_else_branch_sequencer

Control block that sequences the two branch datapaths of a modulation-pipe conditional (`if V == 0 … else …`). It accepts a transaction on `start`, evaluates the condition on `input_bit` and launches exactly one branch unit: the then-unit when `input_bit == 0`, otherwise the else-unit. It waits for that unit's `valid`, registers its result onto `segment_0` and presents the block-level `start`/`valid`/`busy` handshake used by every stage in the pipe. A watchdog guarantees completion when a branch never answers.

## Interface
- WIDTH, 32, data width of branch results and `segment_0`
- MAX_WAIT, 16, cycles in WAIT before timeout; legal range 2..255

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  transaction request; sampled only in IDLE and DONE
- input_bit  in  32  condition operand, captured on an accepted start
- then_start  out  1  one-cycle launch pulse to the then-unit
- then_valid  in  1  then-unit result valid
- then_result  in  WIDTH  then-unit result
- else_start  out  1  one-cycle launch pulse to the else-unit
- else_valid  in  1  else-unit result valid
- else_result  in  WIDTH  else-unit result
- segment_0  out  WIDTH  registered selected result; held until the next capture
- valid  out  1  one-cycle pulse; `segment_0` is valid in this cycle
- busy  out  1  high in LAUNCH and WAIT
- timeout  out  1  sticky; set when the last transaction timed out

## Operation
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE: `busy=0`, `valid=0`. If `start=1`, go to LAUNCH and do the following in the same cycle:
  - register `sel = (input_bit == 32'd0)`; 1 selects then, 0 selects else;
  - clear `timeout` and the wait counter.
- LAUNCH: assert `then_start` if `sel=1`, else `else_start`, for this cycle only. Go to WAIT.
- WAIT: increment the wait counter each cycle.
  - If the selected unit's valid is 1: capture its result into `segment_0` and go to DONE.
  - Otherwise, if the counter equals MAX_WAIT-1: set `timeout=1`, load `segment_0` with 0 and go to DONE.
  - A valid arriving on the same cycle as the timeout condition wins; no timeout is recorded.
  - The non-selected unit's valid and result are ignored in every state.
- DONE: `valid=1` for this cycle.
  - `start=1`: accept a new transaction exactly as IDLE does and go to LAUNCH. This gives back-to-back operation.
  - Otherwise go to IDLE.
- Branch valids seen in IDLE, LAUNCH or DONE are ignored. This covers stale or late results after a timeout or reset.
- `start` asserted in LAUNCH or WAIT is ignored; it is not queued.
- The only condition used is `input_bit == 0`, compared as the full 32-bit word.

## Timing
- Reset (`reset=0`, asynchronous): state=IDLE; `then_start`, `else_start`, `valid`, `busy` and `timeout` are 0; `segment_0` is 0; `sel` is 0; the wait counter is 0. Reset takes effect immediately, mid-transaction included. Release is synchronous to `clk`.
- Let `start` be accepted at edge k and the branch have latency L ≥ 1 (its valid asserted L cycles after its start pulse):
  - the branch start pulse occurs in cycle k+1;
  - the branch valid occurs in cycle k+1+L;
  - `valid` occurs in cycle k+2+L, with `segment_0` already updated.
- Minimum start-to-valid latency is 3 cycles (L=1).
- Timeout case: `valid` asserts MAX_WAIT+1 cycles after the start pulse.
- Back-to-back throughput is one transaction per L+2 cycles.
- All outputs are registered. `valid` and `busy` are never high in the same cycle.

## Test plan
- Then path: with `input_bit=0` and a then-unit of L=1 returning 32'hA5A5_0001, pulse `start` → `then_start` pulses once, `else_start` stays 0, `valid` occurs 3 cycles after start, `segment_0=32'hA5A5_0001`, `timeout=0`.
- Else path with distractor: with `input_bit=32'h0000_0100`, the else-unit at L=4 returning 32'h1234_5678, and the then-unit driving valid with 32'hDEAD_BEEF at L=1 → `segment_0=32'h1234_5678`, and `valid` occurs 6 cycles after start.
- Timeout: with MAX_WAIT=16, the selected unit never responds → `valid` occurs 17 cycles after the launch pulse, `segment_0=0` and `timeout=1`. A late branch valid then causes no second `valid`. The next accepted `start` clears `timeout`.
- Back-to-back: hold `start=1` continuously with alternating `input_bit` values 0 and 5 and L=1 → branch start pulses alternate then, else, then; `valid` pulses every 3 cycles; each `segment_0` matches its own branch.
- Reset mid-WAIT: drive `reset=0` for 1 cycle during WAIT → outputs immediately read the reset values listed above. A branch valid arriving afterwards produces no `valid`, and a new `start` completes normally.
- Boundary: the selected valid arrives exactly on the counter's MAX_WAIT-1 cycle → the result is captured and `timeout=0`. Separately, `start` pulsed during WAIT is ignored and produces no extra transaction.

Source files
------------

// File: rtl/if_else_branch_sequencer.sv
// if_else_branch_sequencer: launches the then- or else-unit on (input_bit == 0) and registers its result, with a watchdog.
module if_else_branch_sequencer #(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      input_bit,
  output logic             then_start,
  input  logic             then_valid,
  input  logic [WIDTH-1:0] then_result,
  output logic             else_start,
  input  logic             else_valid,
  input  logic [WIDTH-1:0] else_result,
  output logic [WIDTH-1:0] segment_0,
  output logic             valid,
  output logic             busy,
  output logic             timeout
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
  state_t state;
  logic sel;
  logic [7:0] cnt;
  logic sel_valid;
  logic [WIDTH-1:0] sel_result;
  logic is_zero;
  always_comb begin
    sel_valid  = sel ? then_valid : else_valid;
    sel_result = sel ? then_result : else_result;
    is_zero    = input_bit == 32'd0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sel        <= 1'b0;
      cnt        <= 8'd0;
      then_start <= 1'b0;
      else_start <= 1'b0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      segment_0  <= '0;
    end else begin
      then_start <= 1'b0;
      else_start <= 1'b0;
      valid      <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LAUNCH;
            sel        <= is_zero;
            cnt        <= 8'd0;
            timeout    <= 1'b0;
            busy       <= 1'b1;
            then_start <= is_zero;
            else_start <= !is_zero;
          end else begin
            state <= IDLE;
          end
        end
        LAUNCH: state <= WAIT;
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (sel_valid || cnt == 8'(MAX_WAIT - 1)) begin
            state     <= DONE;
            valid     <= 1'b1;
            busy      <= 1'b0;
            timeout   <= !sel_valid;
            segment_0 <= sel_valid ? sel_result : '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_if_else_branch_sequencer.sv
// tb_if_else_branch_sequencer: randomized and directed checks against a transaction-level model.
module tb_if_else_branch_sequencer;
  localparam int MAXW = 16;
  logic clk = 0;
  logic reset = 0;
  logic start = 0;
  logic [31:0] input_bit = 0;
  logic then_start, else_start, valid, busy, timeout;
  logic then_valid, else_valid;
  logic [31:0] then_result = 0, else_result = 0, segment_0;
  logic then_resp = 0, else_resp = 0, then_inj = 0, else_inj = 0;
  int then_lat = 0, else_lat = 0, t_pend = -1, e_pend = -1;
  int cyc = 0, chk = 0, errs = 0, overlap = 0;
  int l_q[$];
  int v_cyc[$];
  logic [31:0] v_seg[$];
  logic v_to[$];

  assign then_valid = then_resp | then_inj;
  assign else_valid = else_resp | else_inj;

  if_else_branch_sequencer #(.WIDTH(32), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .start(start), .input_bit(input_bit),
    .then_start(then_start), .then_valid(then_valid), .then_result(then_result),
    .else_start(else_start), .else_valid(else_valid), .else_result(else_result),
    .segment_0(segment_0), .valid(valid), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Branch units: valid is raised L cycles after the cycle carrying their start pulse; latency 0 never answers.
  always @(negedge clk) begin
    if (then_start) t_pend = then_lat > 0 ? then_lat : -1;
    else if (t_pend > 0) t_pend--;
    else t_pend = -1;
    then_resp = t_pend == 0;
    if (else_start) e_pend = else_lat > 0 ? else_lat : -1;
    else if (e_pend > 0) e_pend--;
    else e_pend = -1;
    else_resp = e_pend == 0;
  end

  always @(negedge clk) begin
    if (then_start) l_q.push_back(1);
    if (else_start) l_q.push_back(0);
    if (valid) begin
      v_cyc.push_back(cyc);
      v_seg.push_back(segment_0);
      v_to.push_back(timeout);
    end
    if (valid && busy) overlap++;
  end

  task automatic clear_q();
    l_q.delete();
    v_cyc.delete();
    v_seg.delete();
    v_to.delete();
  endtask

  task automatic run_txn(input string nm, input logic [31:0] x, input int lt, input logic [31:0] data,
                         input bit distract, input int poke);
    bit exp_sel, ok;
    int st, exp_lat, drain;
    logic [31:0] exp_seg;
    exp_sel = x == 32'd0;
    ok = lt >= 1 && lt <= MAXW;
    exp_seg = ok ? data : 32'd0;
    exp_lat = ok ? lt + 2 : MAXW + 2;
    drain = (lt > MAXW ? lt - MAXW : 0) + 4;
    @(negedge clk);
    clear_q();
    then_lat = exp_sel ? lt : 0;
    else_lat = exp_sel ? 0 : lt;
    then_result = exp_sel ? data : $urandom;
    else_result = exp_sel ? $urandom : data;
    then_inj = distract && !exp_sel;
    else_inj = distract && exp_sel;
    st = cyc;
    input_bit = x;
    start = 1;
    @(negedge clk);
    start = 0;
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      start = 1;
      input_bit = $urandom;
      @(negedge clk);
      start = 0;
    end
    for (int i = 0; i < MAXW + 12 && v_cyc.size() == 0; i++) @(negedge clk);
    repeat (drain) @(negedge clk);
    then_inj = 0;
    else_inj = 0;
    chk++;
    if (v_cyc.size() != 1) begin
      errs++;
      $display("FAIL %s valid_count got %0d want 1", nm, v_cyc.size());
    end else begin
      chk += 3;
      if (v_cyc[0] - st != exp_lat) begin
        errs++;
        $display("FAIL %s latency got %0d want %0d", nm, v_cyc[0] - st, exp_lat);
      end
      if (v_seg[0] !== exp_seg) begin
        errs++;
        $display("FAIL %s segment_0 got %h want %h", nm, v_seg[0], exp_seg);
      end
      if (v_to[0] !== !ok) begin
        errs++;
        $display("FAIL %s timeout got %b want %b", nm, v_to[0], !ok);
      end
    end
    chk++;
    if (l_q.size() != 1 || l_q[0] != int'(exp_sel)) begin
      errs++;
      $display("FAIL %s launch count=%0d first=%0d want one pulse sel=%0d", nm, l_q.size(),
               l_q.size() > 0 ? l_q[0] : -1, exp_sel);
    end
    chk++;
    if (timeout !== !ok) begin
      errs++;
      $display("FAIL %s sticky_timeout got %b want %b", nm, timeout, !ok);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk++;
    if ({then_start, else_start, valid, busy, timeout} !== 5'b0 || segment_0 !== 32'd0) begin
      errs++;
      $display("FAIL %s outputs got ts=%b es=%b v=%b b=%b to=%b seg=%h want all 0", nm,
               then_start, else_start, valid, busy, timeout, segment_0);
    end
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1;
    repeat (2) @(negedge clk);
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_then_path();
    run_txn("then_path", 32'd0, 1, 32'hA5A5_0001, 0, 0);
  endtask

  task automatic test_else_distractor();
    run_txn("else_distract", 32'h0000_0100, 4, 32'h1234_5678, 1, 0);
    chk++;
    if (segment_0 !== 32'h1234_5678) begin
      errs++;
      $display("FAIL else_distract held_segment got %h want 12345678", segment_0);
    end
  endtask

  task automatic test_timeout();
    run_txn("timeout", 32'd7, MAXW + 4, 32'hCAFE_0000, 0, 0);
    run_txn("after_timeout", 32'd0, 2, 32'h0BAD_F00D, 0, 0);
  endtask

  task automatic test_boundary();
    run_txn("boundary_then", 32'd0, MAXW, 32'h1111_2222, 0, 0);
    run_txn("boundary_else", 32'h8000_0000, MAXW, 32'h3333_4444, 1, 0);
    run_txn("boundary_over", 32'd0, MAXW + 1, 32'h5555_6666, 0, 0);
    run_txn("start_in_wait", 32'd9, 6, 32'h7777_8888, 0, 2);
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    clear_q();
    then_lat = 1;
    else_lat = 1;
    then_result = 32'hAAAA_0001;
    else_result = 32'hBBBB_0002;
    input_bit = 0;
    start = 1;
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (valid) begin
        n++;
        input_bit = n == 1 ? 32'd5 : 32'd0;
      end
      if (l_q.size() >= 3) start = 0;
    end
    start = 0;
    repeat (6) @(negedge clk);
    chk++;
    if (l_q.size() != 3 || l_q[0] != 1 || l_q[1] != 0 || l_q[2] != 1) begin
      errs++;
      $display("FAIL b2b launch_order count=%0d want then,else,then", l_q.size());
    end
    chk++;
    if (v_cyc.size() != 3) begin
      errs++;
      $display("FAIL b2b valid_count got %0d want 3", v_cyc.size());
    end else begin
      chk += 3;
      if (v_cyc[1] - v_cyc[0] != 3 || v_cyc[2] - v_cyc[1] != 3) begin
        errs++;
        $display("FAIL b2b spacing got %0d,%0d want 3,3", v_cyc[1] - v_cyc[0], v_cyc[2] - v_cyc[1]);
      end
      if (v_seg[0] !== 32'hAAAA_0001 || v_seg[1] !== 32'hBBBB_0002 || v_seg[2] !== 32'hAAAA_0001) begin
        errs++;
        $display("FAIL b2b segments got %h,%h,%h want aaaa0001,bbbb0002,aaaa0001", v_seg[0], v_seg[1], v_seg[2]);
      end
      if (v_to[0] | v_to[1] | v_to[2]) begin
        errs++;
        $display("FAIL b2b timeout got %b%b%b want 000", v_to[0], v_to[1], v_to[2]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    clear_q();
    then_lat = 8;
    else_lat = 0;
    then_result = 32'hFEED_0008;
    input_bit = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    chk++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL rst_mid busy_before got %b want 1", busy);
    end
    #2 reset = 0;
    #1 check_reset_outputs("rst_mid_async");
    @(negedge clk);
    reset = 1;
    repeat (12) @(negedge clk);
    chk++;
    if (v_cyc.size() != 0) begin
      errs++;
      $display("FAIL rst_mid stray_valid got %0d want 0", v_cyc.size());
    end
    run_txn("after_rst", 32'd3, 3, 32'h0000_ABCD, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] x;
    for (int i = 0; i < 12; i++) begin
      x = $urandom_range(0, 1) ? 32'd0 : ($urandom | 32'd1) << $urandom_range(0, 31);
      if (x == 0 && $urandom_range(0, 1) == 0) x = 32'd1 << $urandom_range(0, 31);
      run_txn($sformatf("rand%0d", i), x, $urandom_range(1, MAXW + 3), $urandom,
              bit'($urandom_range(0, 1)), 0);
    end
  endtask

  initial begin
    test_reset();
    test_then_path();
    test_else_distractor();
    test_timeout();
    test_boundary();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    chk++;
    if (overlap != 0) begin
      errs++;
      $display("FAIL valid_busy_overlap got %0d want 0", overlap);
    end
    $display("TB_RESULT checks=%0d failures=%0d", chk, errs);
    $finish;
  end
endmodule
